// File: rtl/risc8_pkg.sv
// risc8_pkg: shared data-memory widths and load/store opcodes for the risc8 core
package risc8_pkg;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;
  typedef enum logic [3:0] {
    OP_LOAD  = 4'h4,
    OP_STORE = 4'h5
  } mem_op_e;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: W-bit up counter with sync clear and all-ones flag
// Ports: clk, rst_n (async, active-low), inc, clr (wins over inc), cnt, sat (cnt is all ones)
// The caller gates inc with sat to make the count saturate.
module arb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);
  assign sat = &cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU load/store path and a host port
// CPU side: cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out.
// Host side: host_req/host_we/host_addr/host_wdata in, host_gnt/host_valid/host_rdata out.
// RAM side: mem_addr/mem_din/mem_we out, mem_dout in. stat_stall_cnt: stall statistics.
// Define DMEM_ARB_STATS_EN to build the saturating CPU stall counter; otherwise stat_stall_cnt is 0.
module dmem_arbiter
  import risc8_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_valid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       stat_stall_cnt
);
  localparam logic [7:0] FORCE_AT = 8'(STARVE_MAX - 1);
  logic       force_q;
  logic [7:0] starve_cnt;
  logic       starve_sat;
  // Gated by rst_n so grants vanish the moment reset is asserted.
  assign host_gnt  = rst_n & host_req & (~cpu_req | force_q);
  assign cpu_stall = cpu_req & host_gnt;
  assign mem_addr  = host_gnt ? host_addr : cpu_addr;
  assign mem_din   = host_gnt ? host_wdata : cpu_wdata;
  assign mem_we    = host_gnt ? host_we : (cpu_req & cpu_we);
  assign cpu_rdata = mem_dout;
  arb_sat_counter #(.W(8)) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (host_req & ~host_gnt & ~starve_sat),
    .clr  (host_gnt | ~host_req),
    .cnt  (starve_cnt),
    .sat  (starve_sat)
  );
  // force_q can only survive one cycle: with host_req held it grants, otherwise it drops.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      force_q    <= 1'b0;
      host_valid <= 1'b0;
      host_rdata <= '0;
    end else begin
      force_q    <= host_req & ~host_gnt & (starve_cnt == FORCE_AT);
      host_valid <= host_gnt;
      if (host_gnt & ~host_we) host_rdata <= mem_dout;
    end
`ifdef DMEM_ARB_STATS_EN
  logic stat_sat;
  arb_sat_counter #(.W(16)) u_stat (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (cpu_stall & ~stat_sat),
    .clr  (1'b0),
    .cnt  (stat_stall_cnt),
    .sat  (stat_sat)
  );
`else
  assign stat_stall_cnt = 16'h0000;
`endif
endmodule
